cdc_fifo_mc: RTL

Multi-channel dual-clock FIFO that carries `NUM_CH` independent data lanes from the `wclk` domain into the `rclk` domain. It is the parametrised successor of the team's single-lane async FIFO. Full/empty are derived from gray-coded pointers passed through multi-flop synchronisers, not from an asynchronous status latch. Each lane adds almost-full, occupancy levels, sticky overflow/underflow and optional first-word fall-through. The block sits between the AFU request path (`wclk`) and the compute pipeline (`rclk`).

---
 rtl/cdc_fifo_pkg.sv | 23 ++
 rtl/cdc_sync_bus.sv | 22 ++
 rtl/cdc_fifo_mc.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared types and helpers for the multi-channel dual-clock FIFO.
package cdc_fifo_pkg;

    localparam int ADDR_LEN_DEF    = 4;
    localparam int SYNC_STAGES_MIN = 2;

    // Pointer at the default depth: ADDR_LEN address bits plus the wrap bit
    typedef logic [ADDR_LEN_DEF:0] ptr_t;

    // Helpers work on a 32-bit container; callers zero-extend and truncate,
    // which leaves the low bits exact for any pointer width up to 32.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int k = 30; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchroniser for a gray-coded bus or a reset-release bit.
// Only gray (single-bit-change) values may be passed through as a bus.
module cdc_sync_bus #(
    parameter int W       = 1,
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] sr;

    // Shift chain; async reset loads RST_VAL into every stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= {(STAGES*W){RST_VAL}};
        else     sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/cdc_fifo_mc.sv
// Multi-channel dual-clock FIFO, wclk -> rclk, gray pointer crossing.
// Build option: CDC_FIFO_FWFT_EN selects first-word fall-through reads.
module cdc_fifo_mc
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_LEN    = 16,
    parameter int ADDR_LEN    = 4,
    parameter int NUM_CH      = 2,
    parameter int AF_THRESH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           rclk,
    input  logic                           PresetFull,
    input  logic                           wclk,
    input  logic [NUM_CH*DATA_LEN-1:0]     data_in,
    input  logic [NUM_CH-1:0]              wrt_en,
    output logic [NUM_CH-1:0]              wrt_full,
    output logic [NUM_CH-1:0]              wrt_almost_full,
    output logic [NUM_CH*(ADDR_LEN+1)-1:0] wrt_level,
    output logic [NUM_CH-1:0]              wrt_overflow,
    output logic [NUM_CH*DATA_LEN-1:0]     data_out,
    input  logic [NUM_CH-1:0]              rd_en,
    output logic [NUM_CH-1:0]              rd_empty,
    output logic [NUM_CH-1:0]              rd_valid,
    output logic [NUM_CH*(ADDR_LEN+1)-1:0] rd_level,
    output logic [NUM_CH-1:0]              rd_underflow
);
    localparam int PW    = ADDR_LEN + 1;
    localparam int DEPTH = 1 << ADDR_LEN;
    localparam int STG   = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic wrst, rrst;

    // Per-domain reset: asserts with PresetFull, releases after STG local edges
    cdc_sync_bus #(.W(1), .STAGES(STG), .RST_VAL(1'b1)) u_wrst (
        .clk(wclk), .rst(PresetFull), .d(1'b0), .q(wrst));
    cdc_sync_bus #(.W(1), .STAGES(STG), .RST_VAL(1'b1)) u_rrst (
        .clk(rclk), .rst(PresetFull), .d(1'b0), .q(rrst));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        logic [DATA_LEN-1:0] mem [DEPTH];
        logic [PW-1:0]       wbin, wgray, wbin_nx, wgray_nx, rq, rq_bin;
        logic [PW-1:0]       rbin, rgray, rbin_nx, rgray_nx, wq, wq_bin;
        logic                push, pop, full_q, empty_q, af_q, ovf_q, udf_q, vld_q;
        logic [DATA_LEN-1:0] dout_q;

        cdc_sync_bus #(.W(PW), .STAGES(STG)) u_rptr_sync (
            .clk(wclk), .rst(wrst), .d(rgray), .q(rq));
        cdc_sync_bus #(.W(PW), .STAGES(STG)) u_wptr_sync (
            .clk(rclk), .rst(rrst), .d(wgray), .q(wq));

        // ---------------- write side ----------------
        assign push     = wrt_en[i] & ~full_q;
        assign wbin_nx  = wbin + PW'(push);
        assign wgray_nx = PW'(bin2gray(32'(wbin_nx)));
        assign rq_bin   = PW'(gray2bin(32'(rq)));

        // Write pointer, almost-full and sticky overflow
        always_ff @(posedge wclk or posedge wrst) begin
            if (wrst) begin
                wbin  <= '0;
                wgray <= '0;
                af_q  <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                wbin  <= wbin_nx;
                wgray <= wgray_nx;
                af_q  <= (wbin_nx - rq_bin) >= PW'(AF_THRESH);
                ovf_q <= ovf_q | (wrt_en[i] & full_q);
            end
        end

        // Full flag, preset directly so it reads full until wrst has released
        always_ff @(posedge wclk or posedge PresetFull) begin
            if (PresetFull) full_q <= 1'b1;
            else            full_q <= (wgray_nx == {~rq[ADDR_LEN -: 2], rq[ADDR_LEN-2:0]});
        end

        // Lane storage, written only by accepted pushes
        always_ff @(posedge wclk) begin
            if (push) mem[wbin[ADDR_LEN-1:0]] <= data_in[i*DATA_LEN +: DATA_LEN];
        end

        // ---------------- read side ----------------
        assign rbin_nx  = rbin + PW'(pop);
        assign rgray_nx = PW'(bin2gray(32'(rbin_nx)));
        assign wq_bin   = PW'(gray2bin(32'(wq)));

        // Read pointer
        always_ff @(posedge rclk or posedge rrst) begin
            if (rrst) begin
                rbin  <= '0;
                rgray <= '0;
            end else begin
                rbin  <= rbin_nx;
                rgray <= rgray_nx;
            end
        end

        // FIFO-empty flag; stays set through rrst since both pointers sit at zero
        always_ff @(posedge rclk or posedge PresetFull) begin
            if (PresetFull) empty_q <= 1'b1;
            else            empty_q <= (rgray_nx == wq);
        end

`ifdef CDC_FIFO_FWFT_EN
        // Refill the one-entry output register whenever it is free or being taken
        assign pop = ~empty_q & (~vld_q | rd_en[i]);

        // Output register holds the head word; rd_en acknowledges it
        always_ff @(posedge rclk or posedge rrst) begin
            if (rrst) begin
                vld_q  <= 1'b0;
                udf_q  <= 1'b0;
                dout_q <= '0;
            end else begin
                udf_q <= udf_q | (rd_en[i] & ~vld_q);
                if (pop) begin
                    dout_q <= mem[rbin[ADDR_LEN-1:0]];
                    vld_q  <= 1'b1;
                end else if (rd_en[i]) begin
                    vld_q  <= 1'b0;
                end
            end
        end

        assign rd_empty[i] = ~vld_q;
`else
        assign pop = rd_en[i] & ~empty_q;

        // Registered read data with a one-cycle valid pulse per pop
        always_ff @(posedge rclk or posedge rrst) begin
            if (rrst) begin
                vld_q  <= 1'b0;
                udf_q  <= 1'b0;
                dout_q <= '0;
            end else begin
                vld_q <= pop;
                udf_q <= udf_q | (rd_en[i] & empty_q);
                if (pop) dout_q <= mem[rbin[ADDR_LEN-1:0]];
            end
        end

        assign rd_empty[i] = empty_q;
`endif

        assign wrt_full[i]                  = full_q | wrst;
        assign wrt_almost_full[i]           = af_q;
        assign wrt_overflow[i]              = ovf_q;
        assign wrt_level[i*PW +: PW]        = wbin - rq_bin;
        assign rd_valid[i]                  = vld_q;
        assign rd_underflow[i]              = udf_q;
        assign rd_level[i*PW +: PW]         = wq_bin - rbin;
        assign data_out[i*DATA_LEN +: DATA_LEN] = dout_q;
    end
endmodule
